// File: rtl/stepgen_vel_ramp_if.sv
// stepgen_vel_ramp_if: host command / stepgen drive bundle for the velocity ramp stage
// master (host): drives cmd_valid, cmd_vel, cmd_accel, tick_div, wd_timeout
// slave (ramp):  drives velocity, enable, at_target, wd_tripped
interface stepgen_vel_ramp_if #(
  parameter int F  = 10,
  parameter int A  = 8,
  parameter int D  = 8,
  parameter int WD = 16
);
  logic              cmd_valid;
  logic signed [F:0] cmd_vel;
  logic [A-1:0]      cmd_accel;
  logic [D-1:0]      tick_div;
  logic [WD-1:0]     wd_timeout;
  logic signed [F:0] velocity;
  logic              enable;
  logic              at_target;
  logic              wd_tripped;
  modport master (
    output cmd_valid, cmd_vel, cmd_accel, tick_div, wd_timeout,
    input  velocity, enable, at_target, wd_tripped
  );
  modport slave (
    input  cmd_valid, cmd_vel, cmd_accel, tick_div, wd_timeout,
    output velocity, enable, at_target, wd_tripped
  );
endinterface

// File: rtl/stepgen_vel_ramp.sv
// stepgen_vel_ramp: latches host velocity commands and slews stepgen velocity toward them with a watchdog stop
// clk, rst_n (sync, active low)
// bus.cmd_valid/cmd_vel/cmd_accel : command strobe, signed target, max step per ramp tick
// bus.tick_div                    : ramp tick every tick_div+1 cycles
// bus.wd_timeout                  : watchdog reload in cycles, 0 disables
// bus.velocity/enable             : registered drive to stepgen
// bus.at_target/wd_tripped        : status
module stepgen_vel_ramp #(
  parameter int F  = 10,
  parameter int A  = 8,
  parameter int D  = 8,
  parameter int WD = 16
) (
  input logic clk,
  input logic rst_n,
  stepgen_vel_ramp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING, TRIPPED} state_t;
  state_t state, state_nx;
  logic signed [F:0] vel, tgt, cmd_clamped, eff_tgt, vel_nx;
  logic [A-1:0] acc;
  logic [D-1:0] pre;
  logic [WD-1:0] wd;
  logic [F+1:0] diff, mag;
  logic [F:0] step;
  logic active, tick, expire;
  assign active = state == RUN || state == STOPPING;
  assign tick = active && pre == '0;
  // the decrement that lands on zero is the expiry; a command that same cycle overrides it
  assign expire = state == RUN && bus.wd_timeout != '0 && wd <= WD'(1) && !bus.cmd_valid;
  // -2^F has no positive counterpart, so pull it in to keep the range symmetric
  assign cmd_clamped = bus.cmd_vel == {1'b1, {F{1'b0}}} ? {1'b1, {(F-1){1'b0}}, 1'b1} : bus.cmd_vel;
  assign eff_tgt = state == STOPPING ? '0 : tgt;
  // one extra bit so target - velocity cannot wrap
  assign diff = {eff_tgt[F], eff_tgt} - {vel[F], vel};
  assign mag = diff[F+1] ? -diff : diff;
  assign step = diff[F+1] ? -(F+1)'(acc) : (F+1)'(acc);
  assign vel_nx = (acc == '0 || mag <= (F+2)'(acc)) ? eff_tgt : vel + step;
  always_comb begin
    state_nx = state;
    state_nx = bus.cmd_valid ? RUN :
               expire ? STOPPING :
               (state == STOPPING && vel == '0) ? TRIPPED : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      vel <= '0;
      tgt <= '0;
      acc <= '0;
      pre <= '0;
      wd <= '0;
    end else begin
      state <= state_nx;
      if (bus.cmd_valid) begin
        tgt <= cmd_clamped;
        acc <= bus.cmd_accel;
      end
      pre <= !active ? '0 : tick ? bus.tick_div : pre - D'(1);
      wd <= bus.cmd_valid ? bus.wd_timeout : (state == RUN && wd != '0) ? wd - WD'(1) : wd;
      vel <= state == TRIPPED ? '0 : tick ? vel_nx : vel;
    end
  end
  assign bus.velocity = vel;
  assign bus.enable = active;
  assign bus.at_target = vel == tgt;
  assign bus.wd_tripped = state == STOPPING || state == TRIPPED;
endmodule
